// File: rtl/pointer_mem_access_pkg.sv
// Shared definitions for the OSECPU pointer-memory access path.
package osecpu_pkg;

    localparam int LBID_W = 12;
    localparam int OFS_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_CHECK,
        ST_MEM,
        ST_DONE
    } pma_state_t;

endpackage

// File: rtl/pointer_mem_access_if.sv
// Request, label-table and memory signals of pointer_mem_access.
// The DUT uses the slave modport; a requester/memory model uses master.
interface pointer_mem_access_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
);

    logic                          req_valid;
    logic                          req_ready;
    logic                          req_we;
    logic [osecpu_pkg::LBID_W-1:0] lbid;
    logic [osecpu_pkg::OFS_W-1:0]  ofs;
    logic [DATA_W-1:0]             wdata;

    logic [osecpu_pkg::LBID_W-1:0] lbl_id;
    logic [ADDR_W-1:0]             lbl_base;
    logic [osecpu_pkg::OFS_W-1:0]  lbl_size;

    logic                          mem_req;
    logic                          mem_we;
    logic [ADDR_W-1:0]             mem_addr;
    logic [DATA_W-1:0]             mem_wdata;
    logic                          mem_ack;
    logic [DATA_W-1:0]             mem_rdata;

    logic                          done;
    logic                          fault;
    logic [DATA_W-1:0]             rdata;

    modport slave (
        input  req_valid, req_we, lbid, ofs, wdata,
        input  lbl_base, lbl_size,
        input  mem_ack, mem_rdata,
        output req_ready, lbl_id,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output done, fault, rdata
    );

    modport master (
        output req_valid, req_we, lbid, ofs, wdata,
        output lbl_base, lbl_size,
        output mem_ack, mem_rdata,
        input  req_ready, lbl_id,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  done, fault, rdata
    );

endinterface

// File: rtl/pointer_mem_access_bounds_check.sv
// Combinational label bounds check: physical address = base + ofs,
// faulting on ofs >= size or on a carry out of the address width.
module ptr_bounds_check
    import osecpu_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] base,
    input  logic [OFS_W-1:0]  size,
    input  logic [OFS_W-1:0]  ofs,
    output logic [ADDR_W-1:0] addr,
    output logic              fault
);

    localparam int SUM_W = ((ADDR_W > OFS_W) ? ADDR_W : OFS_W) + 1;

    logic [SUM_W-1:0] sum;

    always_comb begin
        sum   = SUM_W'(base) + SUM_W'(ofs);
        addr  = sum[ADDR_W-1:0];
        // size == 0 falls out of ofs >= size for every ofs
        fault = (ofs >= size) || (sum[SUM_W-1:ADDR_W] != '0);
    end

endmodule

// File: rtl/pointer_mem_access.sv
// Label-relative load/store engine: looks up a label, bounds-checks the
// pointer offset, then performs one memory access with an ack handshake.
module pointer_mem_access
    import osecpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    pointer_mem_access_if.slave bus
);

    pma_state_t        state_q, state_d;
    logic              we_q;
    logic [LBID_W-1:0] lbid_q;
    logic [OFS_W-1:0]  ofs_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W-1:0] base_q;
    logic [OFS_W-1:0]  size_q;
    logic [ADDR_W-1:0] addr_q;
    logic              fault_q;
    logic [DATA_W-1:0] rdata_q;

    logic [ADDR_W-1:0] chk_addr;
    logic              chk_fault;

    ptr_bounds_check #(
        .ADDR_W(ADDR_W)
    ) u_bounds (
        .base  (base_q),
        .size  (size_q),
        .ofs   (ofs_q),
        .addr  (chk_addr),
        .fault (chk_fault)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.req_valid) state_d = ST_LOOKUP;
            ST_LOOKUP: state_d = ST_CHECK;
            ST_CHECK:  state_d = chk_fault ? ST_DONE : ST_MEM;
            ST_MEM:    if (bus.mem_ack) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            lbid_q  <= '0;
            ofs_q   <= '0;
            wdata_q <= '0;
            base_q  <= '0;
            size_q  <= '0;
            addr_q  <= '0;
            fault_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        we_q    <= bus.req_we;
                        lbid_q  <= bus.lbid;
                        ofs_q   <= bus.ofs;
                        wdata_q <= bus.wdata;
                        fault_q <= 1'b0;
                    end
                end
                ST_LOOKUP: begin
                    base_q <= bus.lbl_base;
                    size_q <= bus.lbl_size;
                end
                ST_CHECK: begin
                    addr_q  <= chk_addr;
                    fault_q <= chk_fault;
                end
                ST_MEM: begin
                    if (bus.mem_ack && !we_q) rdata_q <= bus.mem_rdata;
                end
                default: ;
            endcase
        end
    end

    // req_ready is gated by reset so it reads 0 while reset is held
    assign bus.req_ready = (state_q == ST_IDLE) && !reset;
    assign bus.mem_req   = (state_q == ST_MEM);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.lbl_id    = lbid_q;
    assign bus.fault     = fault_q;
    assign bus.rdata     = rdata_q;

endmodule

// File: tb/tb_pointer_mem_access.sv
// Scoreboard bench for pointer_mem_access: stimulus pushes expected
// responses, a memory responder and a done monitor pop and compare.
module tb_pointer_mem_access;
    import osecpu_pkg::*;

    localparam int DW = 32;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pointer_mem_access_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    pointer_mem_access #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [AW-1:0] base_tab [0:63];
    logic [15:0]   size_tab [0:63];
    assign bus.lbl_base = base_tab[bus.lbl_id[5:0]];
    assign bus.lbl_size = size_tab[bus.lbl_id[5:0]];

    typedef struct {
        logic        fault;
        logic [31:0] rdata;
        int          c0;
    } exp_t;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          c0;
    } mexp_t;

    exp_t        exp_q [$];
    mexp_t       mem_q [$];
    logic [31:0] mem_model [int];

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    int          ack_wait = 0;
    int          last_ack_cyc = 0;
    bit          late_ack = 1'b0;
    logic [31:0] model_rdata = '0;
    logic        model_fault = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event occurred/missing, required the opposite", name);
    endtask

    function automatic logic [31:0] mem_rd(input int a);
        if (mem_model.exists(a)) return mem_model[a];
        return 32'(a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // Memory responder: checks each access and acks after ack_wait cycles.
    initial begin
        logic [15:0] a0;
        logic        we0;
        logic [31:0] wd0;
        int          cnt;
        bit          acked, aborted;
        mexp_t       m;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (reset) continue;
            if (late_ack) begin
                bus.mem_ack = 1'b1;
                @(negedge clk);
                bus.mem_ack = 1'b0;
                late_ack = 1'b0;
                continue;
            end
            if (bus.mem_req) begin
                a0  = bus.mem_addr;
                we0 = bus.mem_we;
                wd0 = bus.mem_wdata;
                if (mem_q.size() == 0) fail_now("unexpected_mem_req");
                else begin
                    m = mem_q.pop_front();
                    chk("mem_we", 64'(we0), 64'(m.we));
                    chk("mem_addr", 64'(a0), 64'(m.addr));
                    if (m.we) chk("mem_wdata", 64'(wd0), 64'(m.wdata));
                    chk("mem_req_latency", 64'(cyc), 64'(m.c0 + 2));
                end
                cnt = 0; acked = 1'b0; aborted = 1'b0;
                while (!acked && !aborted) begin
                    if (ack_wait >= 0 && cnt == ack_wait) begin
                        bus.mem_rdata = we0 ? $urandom : mem_rd(int'(a0));
                        if (we0) mem_model[int'(a0)] = wd0;
                        bus.mem_ack = 1'b1;
                        last_ack_cyc = cyc;
                        acked = 1'b1;
                    end else begin
                        @(negedge clk);
                        cnt++;
                        if (reset) aborted = 1'b1;
                        else if (cnt > 400) begin
                            fail_now("ack_wait_bound");
                            aborted = 1'b1;
                        end else begin
                            chk("mem_req_held", 64'(bus.mem_req), 64'd1);
                            chk("mem_addr_stable", 64'(bus.mem_addr), 64'(a0));
                            chk("mem_we_stable", 64'(bus.mem_we), 64'(we0));
                            chk("mem_wdata_stable", 64'(bus.mem_wdata), 64'(wd0));
                        end
                    end
                end
                if (acked) begin
                    @(negedge clk);
                    bus.mem_ack   = 1'b0;
                    bus.mem_rdata = $urandom;
                    if (!reset) chk("mem_req_drop", 64'(bus.mem_req), 64'd0);
                end
            end
        end
    end

    // Completion monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus.done) begin
                done_cnt++;
                if (exp_q.size() == 0) fail_now("unexpected_done");
                else begin
                    e = exp_q.pop_front();
                    chk("fault", 64'(bus.fault), 64'(e.fault));
                    chk("rdata", 64'(bus.rdata), 64'(e.rdata));
                    chk("done_latency", 64'(cyc),
                        64'(e.fault ? e.c0 + 2 : last_ack_cyc + 1));
                end
            end
        end
    end

    task automatic start_req(input logic [11:0] id, input logic [15:0] o, input logic we,
                             input logic [31:0] wd, input int w, output int c0);
        int          n, b, s;
        logic        f;
        logic [15:0] a;
        logic [31:0] er;
        n = 0;
        c0 = -1;
        while (bus.req_ready !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                fail_now("ready_timeout");
                return;
            end
        end
        chk("fault_held", 64'(bus.fault), 64'(model_fault));
        b = int'(base_tab[id[5:0]]);
        s = int'(size_tab[id[5:0]]);
        f = (int'(o) >= s) || (b + int'(o) > 65535);
        a = 16'(b + int'(o));
        ack_wait = w;
        bus.req_valid = 1'b1;
        bus.lbid      = id;
        bus.ofs       = o;
        bus.req_we    = we;
        bus.wdata     = wd;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.ofs       = 16'($urandom);
        bus.wdata     = $urandom;
        c0 = cyc;
        if (!f) mem_q.push_back('{we, a, wd, c0});
        er = (!f && !we) ? mem_rd(int'(a)) : model_rdata;
        exp_q.push_back('{f, er, c0});
        model_rdata = er;
        model_fault = f;
        chk("lbl_id", 64'(bus.lbl_id), 64'(id));
        chk("ready_busy", 64'(bus.req_ready), 64'd0);
    endtask

    task automatic wait_done();
        int start, n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start) begin
            @(posedge clk);
            n++;
            if (n > 500) begin
                fail_now("done_timeout");
                return;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_req(input logic [11:0] id, input logic [15:0] o, input logic we,
                          input logic [31:0] wd, input int w);
        int c0;
        start_req(id, o, we, wd, w, c0);
        if (c0 >= 0) wait_done();
    endtask

    initial begin
        int          c0, s;
        logic [11:0] id;
        logic [15:0] o;
        for (int i = 0; i < 64; i++) begin
            base_tab[i] = '0;
            size_tab[i] = '0;
        end
        base_tab[1] = 16'h1000; size_tab[1] = 16'd8;
        base_tab[2] = 16'h0200; size_tab[2] = 16'd4;
        base_tab[3] = 16'h3000; size_tab[3] = 16'd8;
        base_tab[4] = 16'h0400; size_tab[4] = 16'd0;
        base_tab[5] = 16'hFFF0; size_tab[5] = 16'h0100;
        for (int i = 8; i < 64; i++) begin
            base_tab[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(65000, 65535))
                                                      : 16'($urandom);
            case ($urandom_range(0, 3))
                0:       size_tab[i] = 16'd0;
                1:       size_tab[i] = 16'($urandom_range(1, 16));
                default: size_tab[i] = 16'($urandom_range(1, 65535));
            endcase
        end
        mem_model[32'h1003] = 32'hDEADBEEF;

        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.lbid      = '0;
        bus.ofs       = '0;
        bus.wdata     = '0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_fault", 64'(bus.fault), 64'd0);
        chk("rst_rdata", 64'(bus.rdata), 64'd0);
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 64'(bus.req_ready), 64'd1);

        // Load, ack two cycles after first mem_req
        do_req(12'd1, 16'd3, 1'b0, 32'h0, 2);
        chk("load_deadbeef", 64'(bus.rdata), 64'hDEADBEEF);
        // Store acked in the first mem_req cycle
        do_req(12'd2, 16'd0, 1'b1, 32'h12345678, 0);
        chk("store_keeps_rdata", 64'(bus.rdata), 64'hDEADBEEF);
        // Bounds, zero-size label, address overflow
        do_req(12'd3, 16'd8, 1'b0, 32'h0, 0);
        do_req(12'd4, 16'd0, 1'b0, 32'h0, 0);
        do_req(12'd5, 16'h0020, 1'b1, 32'hCAFEF00D, 0);
        do_req(12'd3, 16'd7, 1'b0, 32'h0, 1);

        // Backpressure with ignored request pulses while busy
        start_req(12'd1, 16'd5, 1'b0, 32'h0, 10, c0);
        for (int k = 0; k < 5; k++) begin
            bus.req_valid = 1'b1;
            bus.lbid      = 12'd2;
            @(negedge clk);
            chk("ready_busy_pulse", 64'(bus.req_ready), 64'd0);
            bus.req_valid = 1'b0;
            @(negedge clk);
        end
        wait_done();

        for (int t = 0; t < 40; t++) begin
            id = 12'($urandom_range(8, 63));
            s  = int'(size_tab[id[5:0]]);
            o  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, s)) : 16'($urandom);
            do_req(id, o, 1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 4)));
        end

        // Reset while the memory access is outstanding
        start_req(12'd1, 16'd2, 1'b0, 32'h0, -1, c0);
        while (cyc < c0 + 3) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rst_mem_mem_req", 64'(bus.mem_req), 64'd0);
        chk("rst_mem_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_mem_addr0", 64'(bus.mem_addr), 64'd0);
        chk("rst_mem_rdata0", 64'(bus.rdata), 64'd0);
        exp_q.delete();
        mem_q.delete();
        model_rdata = '0;
        model_fault = 1'b0;
        ack_wait = 0;
        @(negedge clk);
        #1 reset = 1'b0;
        late_ack = 1'b1;
        @(negedge clk);
        chk("ready_after_mem_reset", 64'(bus.req_ready), 64'd1);
        repeat (4) begin
            @(negedge clk);
            chk("late_ack_no_mem_req", 64'(bus.mem_req), 64'd0);
            chk("late_ack_no_done", 64'(bus.done), 64'd0);
        end
        do_req(12'd1, 16'd3, 1'b0, 32'h0, 1);

        repeat (3) @(negedge clk);
        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
        chk("mem_q_empty", 64'(mem_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running, required completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail + 1);
        $fatal(1);
    end

endmodule
